// File: rtl/wb_cmd_master_if.sv
// Command-side and Wishbone-side signals of the single-transaction bus master.
// Latency: none, wires only.
// Backpressure: i_cmd_stb is honoured only while o_cmd_busy is low; i_wb_stall holds the request.
// Ports: i_cmd_* command request, o_rsp_* response, o_wb_*/i_wb_* Wishbone B4 pipelined bus.
interface wb_cmd_master_if #(
    parameter int AW = 30
);
    logic          i_cmd_stb;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_addr;
    logic [31:0]   i_cmd_data;
    logic [3:0]    i_cmd_sel;
    logic          i_abort;
    logic          o_cmd_busy;
    logic          o_rsp_stb;
    logic [31:0]   o_rsp_data;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    // The bus master itself.
    modport master (
        input  i_cmd_stb, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_abort,
        output o_cmd_busy, o_rsp_stb, o_rsp_data, o_rsp_err, o_rsp_timeout,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    // The command front end plus the addressed slave, seen from outside.
    modport slave (
        output i_cmd_stb, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_abort,
        input  o_cmd_busy, o_rsp_stb, o_rsp_data, o_rsp_err, o_rsp_timeout,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined master: one command in, one bus cycle, one response out.
// Latency: accept at N, stb at N+1, rsp_stb at N+2 with a zero-wait slave.
// Backpressure: commands dropped while busy; request held while i_wb_stall; optional timeout.
// Ports: i_clk, i_reset_n (async active-low), bus (wb_cmd_master_if.master).
module wb_cmd_master #(
    parameter int AW      = 30,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    wb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam bit            TO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

    state_t        state_q;
    logic          cyc_q;
    logic          stb_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [3:0]    sel_q;
    logic          rsp_stb_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;
    logic          rsp_timeout_q;
    logic [TW-1:0] cnt_q;

    logic timeout_hit;
    assign timeout_hit = TO_EN && (cnt_q == TO_VAL);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            sel_q         <= '0;
            rsp_stb_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Response strobe is a single-cycle pulse unless re-asserted below.
            rsp_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_cmd_stb) begin
                        we_q    <= bus.i_cmd_we;
                        addr_q  <= bus.i_cmd_addr;
                        data_q  <= bus.i_cmd_data;
                        sel_q   <= bus.i_cmd_sel;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (bus.i_abort) begin
                        // Abort beats any same-cycle ack/err: the cycle vanishes silently.
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (bus.i_wb_err || bus.i_wb_ack || timeout_hit) begin
                        // Priority err > ack > timeout; data only survives a clean ack.
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_stb_q     <= 1'b1;
                        rsp_err_q     <= bus.i_wb_err;
                        rsp_timeout_q <= !bus.i_wb_err && !bus.i_wb_ack;
                        rsp_data_q    <= (bus.i_wb_ack && !bus.i_wb_err) ? bus.i_wb_data : 32'h0;
                        state_q       <= S_IDLE;
                    end else begin
                        if (state_q == S_REQ && !bus.i_wb_stall) begin
                            stb_q   <= 1'b0;
                            state_q <= S_WAIT;
                        end
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Busy tracks the bus cycle exactly, so it is already low in the response cycle.
    assign bus.o_cmd_busy    = cyc_q;
    assign bus.o_rsp_stb     = rsp_stb_q;
    assign bus.o_rsp_data    = rsp_data_q;
    assign bus.o_rsp_err     = rsp_err_q;
    assign bus.o_rsp_timeout = rsp_timeout_q;
    assign bus.o_wb_cyc      = cyc_q;
    assign bus.o_wb_stb      = stb_q;
    assign bus.o_wb_we       = we_q;
    assign bus.o_wb_addr     = addr_q;
    assign bus.o_wb_data     = data_q;
    assign bus.o_wb_sel      = sel_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a response scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Slave behaviour is scripted per step in the main sequence.
module tb_wb_cmd_master;
    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic        t;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   starts = 0;
    logic prev_cyc = 1'b0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    wb_cmd_master_if #(.AW(30)) bus();

    wb_cmd_master #(.AW(30), .TIMEOUT(8), .TW(10)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic we, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_we   = we;
        bus.i_cmd_addr = a;
        bus.i_cmd_data = d;
        bus.i_cmd_sel  = s;
    endtask

    // Scoreboard consumer and bus-cycle start counter.
    always @(negedge clk) begin
        if (bus.o_rsp_stb) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_rsp: observed=rsp_stb expected=no response");
            end
            if (exp_q.size() > 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("sb_rsp_data", bus.o_rsp_data, e.d);
                chk("sb_rsp_err", 32'(bus.o_rsp_err), 32'(e.e));
                chk("sb_rsp_timeout", 32'(bus.o_rsp_timeout), 32'(e.t));
            end
        end
        if (bus.o_wb_cyc && !prev_cyc) starts++;
        prev_cyc = bus.o_wb_cyc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int s0;
        bus.i_cmd_stb  = 1'b0;
        bus.i_cmd_we   = 1'b0;
        bus.i_cmd_addr = '0;
        bus.i_cmd_data = '0;
        bus.i_cmd_sel  = '0;
        bus.i_abort    = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_data  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(bus.o_wb_stb), 32'd0);
        chk("rst_busy", 32'(bus.o_cmd_busy), 32'd0);
        chk("rst_rsp_stb", 32'(bus.o_rsp_stb), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write.
        drive_cmd(1'b1, 30'h10, 32'h0001_0001, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        chk("zw_cyc", 32'(bus.o_wb_cyc), 32'd1);
        chk("zw_stb", 32'(bus.o_wb_stb), 32'd1);
        chk("zw_busy", 32'(bus.o_cmd_busy), 32'd1);
        chk("zw_we", 32'(bus.o_wb_we), 32'd1);
        chk("zw_addr", 32'(bus.o_wb_addr), 32'h10);
        chk("zw_data", bus.o_wb_data, 32'h0001_0001);
        chk("zw_sel", 32'(bus.o_wb_sel), 32'hF);
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 32'h0000_1234;
        exp_q.push_back('{d: 32'h0000_1234, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("zw_stb_low", 32'(bus.o_wb_stb), 32'd0);
        chk("zw_cyc_low", 32'(bus.o_wb_cyc), 32'd0);
        chk("zw_busy_low", 32'(bus.o_cmd_busy), 32'd0);
        chk("zw_rsp_stb", 32'(bus.o_rsp_stb), 32'd1);
        @(negedge clk);
        chk("zw_rsp_once", 32'(bus.o_rsp_stb), 32'd0);

        // Stalled read: stb held four cycles, ack two cycles after stb drops.
        drive_cmd(1'b0, 30'h20, 32'hFFFF_0000, 4'h3);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_stb", 32'(bus.o_wb_stb), 32'd1);
            chk("st_addr", 32'(bus.o_wb_addr), 32'h20);
            chk("st_we", 32'(bus.o_wb_we), 32'd0);
            bus.i_wb_stall = (i < 3);
            @(negedge clk);
        end
        chk("st_stb_drop", 32'(bus.o_wb_stb), 32'd0);
        chk("st_wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
        @(negedge clk);
        chk("st_wait_busy", 32'(bus.o_cmd_busy), 32'd1);
        @(negedge clk);
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 32'hA5A5_0003;
        exp_q.push_back('{d: 32'hA5A5_0003, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("st_rsp_stb", 32'(bus.o_rsp_stb), 32'd1);
        chk("st_rsp_data", bus.o_rsp_data, 32'hA5A5_0003);
        chk("st_cyc_low", 32'(bus.o_wb_cyc), 32'd0);

        // Error together with ack: error wins, data forced to zero.
        drive_cmd(1'b0, 30'h30, 32'h0, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_err  = 1'b1;
        bus.i_wb_data = 32'hDEAD_BEEF;
        exp_q.push_back('{d: 32'h0, e: 1'b1, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        bus.i_wb_err = 1'b0;
        chk("er_rsp_stb", 32'(bus.o_rsp_stb), 32'd1);
        chk("er_rsp_err", 32'(bus.o_rsp_err), 32'd1);
        chk("er_rsp_data", bus.o_rsp_data, 32'h0);
        @(negedge clk);
        chk("er_rsp_once", 32'(bus.o_rsp_stb), 32'd0);

        // Timeout with TIMEOUT=8: counter 0..8 spans nine cyc cycles.
        drive_cmd(1'b0, 30'h40, 32'h0, 4'hF);
        exp_q.push_back('{d: 32'h0, e: 1'b0, t: 1'b1});
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        n = 0;
        while (bus.o_wb_cyc && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("to_cyc_cycles", 32'(n), 32'd9);
        chk("to_rsp_stb", 32'(bus.o_rsp_stb), 32'd1);
        chk("to_rsp_timeout", 32'(bus.o_rsp_timeout), 32'd1);
        drive_cmd(1'b1, 30'h44, 32'hCAFE_0001, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        chk("to_next_stb", 32'(bus.o_wb_stb), 32'd1);
        chk("to_next_addr", 32'(bus.o_wb_addr), 32'h44);
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 32'h5A5A_0044;
        exp_q.push_back('{d: 32'h5A5A_0044, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("to_next_rsp", 32'(bus.o_rsp_stb), 32'd1);
        chk("to_next_timeout", 32'(bus.o_rsp_timeout), 32'd0);
        @(negedge clk);

        // Abort in WAIT, then a late ack that must be ignored.
        drive_cmd(1'b0, 30'h50, 32'h0, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        chk("ab_stb", 32'(bus.o_wb_stb), 32'd1);
        @(negedge clk);
        chk("ab_wait_stb", 32'(bus.o_wb_stb), 32'd0);
        chk("ab_wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("ab_cyc_low", 32'(bus.o_wb_cyc), 32'd0);
        chk("ab_busy_low", 32'(bus.o_cmd_busy), 32'd0);
        chk("ab_no_rsp", 32'(bus.o_rsp_stb), 32'd0);
        bus.i_wb_ack = 1'b1;
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("ab_late_ack_rsp", 32'(bus.o_rsp_stb), 32'd0);
        chk("ab_late_ack_cyc", 32'(bus.o_wb_cyc), 32'd0);

        // Abort coinciding with ack still suppresses the response.
        drive_cmd(1'b0, 30'h54, 32'h0, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        bus.i_wb_ack  = 1'b1;
        bus.i_abort   = 1'b1;
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        bus.i_abort  = 1'b0;
        chk("abk_no_rsp", 32'(bus.o_rsp_stb), 32'd0);
        chk("abk_cyc_low", 32'(bus.o_wb_cyc), 32'd0);

        // Abort in IDLE alongside a command has no effect.
        drive_cmd(1'b0, 30'h58, 32'h0, 4'hF);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        bus.i_abort   = 1'b0;
        chk("abi_cyc", 32'(bus.o_wb_cyc), 32'd1);
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 32'h0BAD_0058;
        exp_q.push_back('{d: 32'h0BAD_0058, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("abi_rsp", 32'(bus.o_rsp_stb), 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a stalled request.
        drive_cmd(1'b1, 30'h60, 32'h1111_2222, 4'h5);
        @(negedge clk);
        bus.i_cmd_stb  = 1'b0;
        bus.i_wb_stall = 1'b1;
        chk("rs_stb", 32'(bus.o_wb_stb), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_cyc", 32'(bus.o_wb_cyc), 32'd0);
        chk("rs_stb0", 32'(bus.o_wb_stb), 32'd0);
        chk("rs_busy", 32'(bus.o_cmd_busy), 32'd0);
        chk("rs_we", 32'(bus.o_wb_we), 32'd0);
        chk("rs_addr", 32'(bus.o_wb_addr), 32'h0);
        chk("rs_data", bus.o_wb_data, 32'h0);
        chk("rs_sel", 32'(bus.o_wb_sel), 32'h0);
        chk("rs_rsp_data", bus.o_rsp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_wb_stall = 1'b0;
        @(negedge clk);
        chk("rs_after_cyc", 32'(bus.o_wb_cyc), 32'd0);

        // Back-to-back: command during rsp cycle accepted; command while busy dropped.
        s0 = starts;
        drive_cmd(1'b1, 30'h70, 32'h0000_0001, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 32'h0000_0070;
        exp_q.push_back('{d: 32'h0000_0070, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("bb_rsp_stb", 32'(bus.o_rsp_stb), 32'd1);
        chk("bb_busy_low", 32'(bus.o_cmd_busy), 32'd0);
        drive_cmd(1'b0, 30'h74, 32'h0, 4'hF);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        chk("bb_second_stb", 32'(bus.o_wb_stb), 32'd1);
        chk("bb_second_addr", 32'(bus.o_wb_addr), 32'h74);
        bus.i_wb_stall = 1'b1;
        drive_cmd(1'b1, 30'h78, 32'hFFFF_FFFF, 4'h1);
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        chk("bb_busy_stb", 32'(bus.o_wb_stb), 32'd1);
        chk("bb_busy_addr", 32'(bus.o_wb_addr), 32'h74);
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b1;
        bus.i_wb_data  = 32'h0000_0074;
        exp_q.push_back('{d: 32'h0000_0074, e: 1'b0, t: 1'b0});
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        chk("bb_second_rsp", 32'(bus.o_rsp_stb), 32'd1);
        repeat (3) @(negedge clk);
        chk("bb_idle_cyc", 32'(bus.o_wb_cyc), 32'd0);
        chk("bb_cycle_count", 32'(starts - s0), 32'd2);
        chk("bb_dropped_addr", 32'(bus.o_wb_addr), 32'h74);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
